// File: rtl/bp_history_queue_if.sv
// Fetch/back-end side bundle of the branch history queue: allocation, resolution,
// flush and the registered predictor-update outputs.
interface bp_history_queue_if #(
  parameter int unsigned GHR_WIDTH = 13,
  parameter int unsigned PTR_W     = 3
);
  logic                 alloc_valid;
  logic                 alloc_ready;
  logic [31:0]          alloc_pc;
  logic [GHR_WIDTH-1:0] alloc_ghr;
  logic                 alloc_pred;
  logic                 resolve_valid;
  logic                 resolve_taken;
  logic                 flush;
  logic                 update_en;
  logic [31:0]          update_pc;
  logic [GHR_WIDTH-1:0] update_ghr_val;
  logic                 actual_taken;
  logic                 mispredict;
  logic [GHR_WIDTH-1:0] recover_ghr;
  logic [PTR_W:0]       count;
  logic                 resolve_err;

  modport master (
    output alloc_valid, alloc_pc, alloc_ghr, alloc_pred,
    output resolve_valid, resolve_taken, flush,
    input  alloc_ready, update_en, update_pc, update_ghr_val, actual_taken,
    input  mispredict, recover_ghr, count, resolve_err
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_ghr, alloc_pred,
    input  resolve_valid, resolve_taken, flush,
    output alloc_ready, update_en, update_pc, update_ghr_val, actual_taken,
    output mispredict, recover_ghr, count, resolve_err
  );
endinterface

// File: rtl/bp_history_queue.sv
// In-order queue of predicted branches between fetch and the gshare update port;
// pops on resolve and emits a registered one-cycle predictor update.
module bp_history_queue #(
  parameter int unsigned K         = 13,
  parameter int unsigned GHR_WIDTH = K,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PTR_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  bp_history_queue_if.slave     bus
);

  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]          pc;
    logic [GHR_WIDTH-1:0] ghr;
    logic                 pred;
  } entry_t;

  entry_t               mem_q [DEPTH];
  entry_t               mem_d [DEPTH];
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 update_en_q, update_en_d;
  logic [31:0]          update_pc_q, update_pc_d;
  logic [GHR_WIDTH-1:0] update_ghr_q, update_ghr_d;
  logic                 actual_taken_q, actual_taken_d;
  logic                 mispredict_q, mispredict_d;
  logic [GHR_WIDTH-1:0] recover_ghr_q, recover_ghr_d;
  logic                 resolve_err_q, resolve_err_d;

  logic   full, empty, push, pop;
  entry_t head_e;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == CNT_W'(0));
  // A flush discards the same-cycle push, so it never touches storage.
  assign push   = bus.alloc_valid & ~full & ~bus.flush;
  assign pop    = bus.resolve_valid & ~empty;
  assign head_e = mem_q[head_q];

  always_comb begin
    mem_d          = mem_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    update_en_d    = 1'b0;
    mispredict_d   = 1'b0;
    update_pc_d    = update_pc_q;
    update_ghr_d   = update_ghr_q;
    actual_taken_d = actual_taken_q;
    recover_ghr_d  = recover_ghr_q;
    resolve_err_d  = resolve_err_q;

    if (push) begin
      mem_d[tail_q] = '{pc: bus.alloc_pc, ghr: bus.alloc_ghr, pred: bus.alloc_pred};
      tail_d        = tail_q + PTR_W'(1);
    end

    if (pop) begin
      head_d         = head_q + PTR_W'(1);
      update_en_d    = 1'b1;
      update_pc_d    = head_e.pc;
      update_ghr_d   = head_e.ghr;
      actual_taken_d = bus.resolve_taken;
      mispredict_d   = head_e.pred ^ bus.resolve_taken;
      recover_ghr_d  = {head_e.ghr[GHR_WIDTH-2:0], bus.resolve_taken};
    end

    if (bus.resolve_valid && empty) begin
      resolve_err_d = 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      update_en_q    <= 1'b0;
      update_pc_q    <= '0;
      update_ghr_q   <= '0;
      actual_taken_q <= 1'b0;
      mispredict_q   <= 1'b0;
      recover_ghr_q  <= '0;
      resolve_err_q  <= 1'b0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      update_en_q    <= update_en_d;
      update_pc_q    <= update_pc_d;
      update_ghr_q   <= update_ghr_d;
      actual_taken_q <= actual_taken_d;
      mispredict_q   <= mispredict_d;
      recover_ghr_q  <= recover_ghr_d;
      resolve_err_q  <= resolve_err_d;
    end
  end

  // Entry storage carries no reset; contents are only read behind a valid count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.alloc_ready    = ~full;
  assign bus.update_en      = update_en_q;
  assign bus.update_pc      = update_pc_q;
  assign bus.update_ghr_val = update_ghr_q;
  assign bus.actual_taken   = actual_taken_q;
  assign bus.mispredict     = mispredict_q;
  assign bus.recover_ghr    = recover_ghr_q;
  assign bus.count          = count_q;
  assign bus.resolve_err    = resolve_err_q;

endmodule

// File: tb/tb_bp_history_queue.sv
// Randomized and directed bench for bp_history_queue: a queue-based reference model
// feeds an update scoreboard that a negedge monitor drains.
module tb_bp_history_queue;

  localparam int unsigned GW    = 13;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PW    = 3;

  typedef struct {
    logic [31:0]   pc;
    logic [GW-1:0] ghr;
    logic          pred;
  } ent_t;

  typedef struct {
    int            due;
    logic [31:0]   pc;
    logic [GW-1:0] ghr;
    logic          act;
    logic          misp;
    logic [GW-1:0] rec;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  bp_history_queue_if #(.GHR_WIDTH(GW), .PTR_W(PW)) bus ();

  bp_history_queue #(.K(GW), .GHR_WIDTH(GW), .DEPTH(DEPTH), .PTR_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rst_sampled = 1'b0;
  logic mon_en = 1'b0;

  ent_t mq[$];
  exp_t exp_q[$];
  logic m_err = 1'b0;

  logic [31:0]   held_pc  = '0;
  logic [GW-1:0] held_ghr = '0;
  logic          held_act = 1'b0;
  logic [GW-1:0] held_rec = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    rst_sampled = rst;
  end

  // Monitor: every update pulse must match the oldest scoreboard entry due this cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_sampled) begin
        held_pc  = '0;
        held_ghr = '0;
        held_act = 1'b0;
        held_rec = '0;
      end
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_update: got none expected pc 0x%0h due cycle %0d", exp_q[0].pc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("update_en", 64'(bus.update_en), 64'(1));
        chk("update_pc", 64'(bus.update_pc), 64'(e.pc));
        chk("update_ghr_val", 64'(bus.update_ghr_val), 64'(e.ghr));
        chk("actual_taken", 64'(bus.actual_taken), 64'(e.act));
        chk("mispredict", 64'(bus.mispredict), 64'(e.misp));
        chk("recover_ghr", 64'(bus.recover_ghr), 64'(e.rec));
        held_pc  = e.pc;
        held_ghr = e.ghr;
        held_act = e.act;
        held_rec = e.rec;
      end else begin
        chk("idle_update_en", 64'(bus.update_en), 64'(0));
        chk("idle_mispredict", 64'(bus.mispredict), 64'(0));
        chk("hold_update_pc", 64'(bus.update_pc), 64'(held_pc));
        chk("hold_update_ghr", 64'(bus.update_ghr_val), 64'(held_ghr));
        chk("hold_actual", 64'(bus.actual_taken), 64'(held_act));
        chk("hold_recover", 64'(bus.recover_ghr), 64'(held_rec));
      end
    end
  end

  // One clock of stimulus; the reference model advances alongside it.
  task automatic step(input logic av, input logic [31:0] pc, input logic [GW-1:0] ghr,
                      input logic pred, input logic rv, input logic tk,
                      input logic fl, input logic r);
    bit ready, do_pop, do_push;
    bus.alloc_valid   = av;
    bus.alloc_pc      = pc;
    bus.alloc_ghr     = ghr;
    bus.alloc_pred    = pred;
    bus.resolve_valid = rv;
    bus.resolve_taken = tk;
    bus.flush         = fl;
    rst               = r;

    if (!r) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      ready   = (mq.size() < DEPTH);
      do_pop  = rv && (mq.size() > 0);
      do_push = av && ready && !fl;
      if (rv && mq.size() == 0) m_err = 1'b1;
      if (do_pop) begin
        ent_t h;
        exp_t x;
        logic [GW-1:0] g;
        h = mq.pop_front();
        g = h.ghr;
        x.due  = cyc + 1;
        x.pc   = h.pc;
        x.ghr  = h.ghr;
        x.act  = tk;
        x.misp = h.pred ^ tk;
        x.rec  = {g[GW-2:0], tk};
        exp_q.push_back(x);
      end
      if (fl) mq.delete();
      else if (do_push) mq.push_back('{pc: pc, ghr: ghr, pred: pred});
    end

    @(posedge clk);
    #1;
    chk("count", 64'(bus.count), 64'(mq.size()));
    chk("resolve_err", 64'(bus.resolve_err), 64'(m_err));
    chk("alloc_ready", 64'(bus.alloc_ready), 64'(mq.size() < DEPTH));
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic push(input logic [31:0] pc, input logic [GW-1:0] ghr, input logic pred);
    step(1'b1, pc, ghr, pred, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic resolve(input logic tk);
    step(1'b0, '0, '0, 1'b0, 1'b1, tk, 1'b0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < int'(DEPTH) && mq.size() > 0; i++) resolve(1'($urandom));
  endtask

  initial begin
    bus.alloc_valid   = 1'b0;
    bus.alloc_pc      = '0;
    bus.alloc_ghr     = '0;
    bus.alloc_pred    = 1'b0;
    bus.resolve_valid = 1'b0;
    bus.resolve_taken = 1'b0;
    bus.flush         = 1'b0;
    rst               = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();

    // Single mispredicted branch.
    push(32'h1000, 13'h0AA, 1'b1);
    resolve(1'b0);
    idle();
    idle();

    // Fill, dropped ninth push, back-to-back drain.
    for (int i = 0; i < 8; i++) push(32'h100 + 32'(4 * i), GW'($urandom), 1'($urandom));
    push(32'hDEAD, GW'($urandom), 1'b1);
    for (int i = 0; i < 8; i++) resolve(1'($urandom));
    idle();

    // Full with push+resolve, then steady push+resolve at count 3 across wrap.
    for (int i = 0; i < 8; i++) push(32'h200 + 32'(4 * i), GW'($urandom), 1'($urandom));
    step(1'b1, 32'hBAD0, GW'($urandom), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) resolve(1'($urandom));
    for (int i = 0; i < 14; i++)
      step(1'b1, 32'h300 + 32'(4 * i), GW'($urandom), 1'($urandom), 1'b1, 1'($urandom), 1'b0, 1'b1);
    drain();

    // Resolve while empty, then push+resolve from empty.
    resolve(1'b1);
    idle();
    step(1'b1, 32'h400, GW'($urandom), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drain();

    // Flush with a same-cycle pop, then refill from index 0.
    for (int i = 0; i < 4; i++) push(32'h500 + 32'(4 * i), GW'($urandom), 1'($urandom));
    step(1'b1, 32'hF00, GW'($urandom), 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    push(32'h600, GW'($urandom), 1'b0);
    resolve(1'b1);
    idle();

    // Reset landing on a pending resolve.
    push(32'h700, GW'($urandom), 1'b1);
    push(32'h704, GW'($urandom), 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 60), $urandom, GW'($urandom), 1'($urandom),
           1'($urandom_range(0, 99) < 45), 1'($urandom),
           1'($urandom_range(0, 99) < 4), 1'($urandom_range(0, 99) >= 2));
    end
    drain();
    idle();
    idle();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
